// File: rtl/dma_timing_ctrl_if.sv
// Bus-side handshake and strobe bundle of the 8237-style DMA timing controller.
// The master modport is the controller; the slave modport is the CPU/bus side.
interface dma_timing_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16
);
  logic [NUM_CH-1:0] DREQ;
  logic              HLDA;
  logic              EOP_N_IN;
  logic              HRQ;
  logic [NUM_CH-1:0] DACK;
  logic              idle_cycle;
  logic              active_cycle;
  logic              ior;
  logic              iow;
  logic              memr;
  logic              memw;
  logic              aen;
  logic              adstb;
  logic              eop;
  logic [ADDR_W-1:0] addr_out;

  modport master (
    input  DREQ, HLDA, EOP_N_IN,
    output HRQ, DACK, idle_cycle, active_cycle, ior, iow, memr, memw,
           aen, adstb, eop, addr_out
  );

  modport slave (
    output DREQ, HLDA, EOP_N_IN,
    input  HRQ, DACK, idle_cycle, active_cycle, ior, iow, memr, memw,
           aen, adstb, eop, addr_out
  );
endinterface

// File: rtl/dma_timing_ctrl.sv
// 8237-style DMA timing/priority controller: SI/S0/S1-S4 single-transfer sequencing.
// Define DMA_ROTATING_PRIORITY_EN for rotating priority; fixed priority (ch0 highest) otherwise.
module dma_timing_ctrl #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  dma_timing_ctrl_if.master        bus,
  input  logic                     cfg_enable,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [2*NUM_CH-1:0]      ch_xfer_type,
  input  logic [NUM_CH-1:0]        ch_load,
  input  logic [ADDR_W*NUM_CH-1:0] ch_base_addr,
  input  logic [CNT_W*NUM_CH-1:0]  ch_base_count,
  output logic [NUM_CH-1:0]        tc_status
);
  localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

  state_t            state;
  logic [GW-1:0]     grant;
  logic [1:0]        xfer;
  logic              tc_pend;
  logic              hrq, idle, active, ior, iow, memr, memw, aen, adstb, eop;
  logic [NUM_CH-1:0] dack;
  logic [ADDR_W-1:0] cur_addr  [NUM_CH];
  logic [CNT_W-1:0]  cur_count [NUM_CH];

  logic [NUM_CH-1:0] elig;
  logic [GW-1:0]     winner;
  logic [1:0]        win_type;
  logic              found;
  logic              abort;
  logic              tc_now;

  assign elig   = bus.DREQ & ~ch_mask & ~tc_status & {NUM_CH{cfg_enable}};
  assign abort  = (state inside {S1, S2, S3}) && !bus.HLDA;
  assign tc_now = tc_pend || !bus.EOP_N_IN || (cur_count[grant] == '0);

`ifdef DMA_ROTATING_PRIORITY_EN
  logic [GW-1:0] hi_ptr;
  logic [GW-1:0] idx;

  // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = GW'((int'(hi_ptr) + k) % NUM_CH);
      if (!found && elig[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end
`else
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && elig[i]) begin
        winner = GW'(i);
        found  = 1'b1;
      end
    end
  end
`endif

  assign win_type = ch_xfer_type[2*int'(winner) +: 2];

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= SI;
      grant     <= '0;
      xfer      <= 2'b00;
      tc_pend   <= 1'b0;
      hrq       <= 1'b0;
      dack      <= '0;
      idle      <= 1'b1;
      active    <= 1'b0;
      {ior, iow, memr, memw} <= 4'b1111;
      aen       <= 1'b0;
      adstb     <= 1'b0;
      eop       <= 1'b1;
      tc_status <= '0;
`ifdef DMA_ROTATING_PRIORITY_EN
      hi_ptr    <= '0;
`endif
      // NOTE: the per-channel register file is small and must read 0 after reset, so it is reset like flops.
      for (int i = 0; i < NUM_CH; i++) begin
        cur_addr[i]  <= '0;
        cur_count[i] <= '0;
      end
    end else begin
      if (abort) begin
        state  <= SI;
        hrq    <= 1'b0;
        dack   <= '0;
        aen    <= 1'b0;
        adstb  <= 1'b0;
        idle   <= 1'b1;
        active <= 1'b0;
        {ior, iow, memr, memw} <= 4'b1111;
      end else begin
        case (state)
          SI: if (|elig) begin
            state <= S0;
            hrq   <= 1'b1;
          end
          S0: if (!(|elig)) begin
            state <= SI;
            hrq   <= 1'b0;
          end else if (bus.HLDA) begin
            state   <= S1;
            grant   <= winner;
            xfer    <= win_type;
            dack    <= NUM_CH'(1) << winner;
            aen     <= 1'b1;
            adstb   <= 1'b1;
            idle    <= 1'b0;
            active  <= 1'b1;
            tc_pend <= 1'b0;
          end
          S1: begin
            state <= S2;
            adstb <= 1'b0;
            ior   <= (xfer != 2'b01);
            memr  <= (xfer != 2'b10);
          end
          S2: begin
            state <= S3;
            memw  <= (xfer != 2'b01);
            iow   <= (xfer != 2'b10);
            if (!bus.EOP_N_IN) tc_pend <= 1'b1;
          end
          S3: begin
            state   <= S4;
            {ior, iow, memr, memw} <= 4'b1111;
            tc_pend <= tc_now;
            eop     <= !tc_now;
          end
          S4: begin
            state  <= SI;
            hrq    <= 1'b0;
            dack   <= '0;
            aen    <= 1'b0;
            idle   <= 1'b1;
            active <= 1'b0;
            eop    <= 1'b1;
            cur_addr[grant]  <= cur_addr[grant] + ADDR_W'(1);
            cur_count[grant] <= cur_count[grant] - CNT_W'(1);
            if (tc_pend) tc_status[grant] <= 1'b1;
`ifdef DMA_ROTATING_PRIORITY_EN
            hi_ptr <= (grant == GW'(NUM_CH - 1)) ? '0 : grant + GW'(1);
`endif
          end
          default: state <= SI;
        endcase
      end
      // Placed last so a load on the granted channel overrides the S4 update.
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_load[i]) begin
          cur_addr[i]  <= ch_base_addr[i*ADDR_W +: ADDR_W];
          cur_count[i] <= ch_base_count[i*CNT_W +: CNT_W];
          tc_status[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.HRQ          = hrq;
  assign bus.DACK         = dack;
  assign bus.idle_cycle   = idle;
  assign bus.active_cycle = active;
  assign bus.ior          = ior;
  assign bus.iow          = iow;
  assign bus.memr         = memr;
  assign bus.memw         = memw;
  assign bus.aen          = aen;
  assign bus.adstb        = adstb;
  assign bus.eop          = eop;
  assign bus.addr_out     = cur_addr[grant];
endmodule

// File: tb/tb_dma_timing_ctrl.sv
// Directed self-checking bench for dma_timing_ctrl: one task per scenario.
// Honours DMA_ROTATING_PRIORITY_EN for the priority-order expectation.
module tb_dma_timing_ctrl;
  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        cfg_enable;
  logic [3:0]  ch_mask;
  logic [7:0]  ch_xfer_type;
  logic [3:0]  ch_load;
  logic [63:0] ch_base_addr;
  logic [63:0] ch_base_count;
  logic [3:0]  tc_status;

  int errors = 0;
  int checks = 0;

  // {HRQ, DACK, idle, active, ior, iow, memr, memw, aen, adstb, eop}
  localparam logic [13:0] RST_PACK = 14'b0_0000_1_0_1111_0_0_1;

  typedef struct {
    logic [3:0]  dack;
    logic [3:0]  strb;   // {ior, iow, memr, memw}
    logic        aen, adstb, eop, hrq, idle, active;
    logic [15:0] addr;
    logic [3:0]  tc;
  } snap_t;

  snap_t snap [5];       // S1, S2, S3, S4, back in SI

  dma_timing_ctrl_if bus ();

  dma_timing_ctrl dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .bus           (bus),
    .cfg_enable    (cfg_enable),
    .ch_mask       (ch_mask),
    .ch_xfer_type  (ch_xfer_type),
    .ch_load       (ch_load),
    .ch_base_addr  (ch_base_addr),
    .ch_base_count (ch_base_count),
    .tc_status     (tc_status)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic grab(input int k);
    snap[k].dack   = bus.DACK;
    snap[k].strb   = {bus.ior, bus.iow, bus.memr, bus.memw};
    snap[k].aen    = bus.aen;
    snap[k].adstb  = bus.adstb;
    snap[k].eop    = bus.eop;
    snap[k].hrq    = bus.HRQ;
    snap[k].idle   = bus.idle_cycle;
    snap[k].active = bus.active_cycle;
    snap[k].addr   = bus.addr_out;
    snap[k].tc     = tc_status;
  endtask

  task automatic load_ch(input int ch, input logic [15:0] addr, input logic [15:0] cnt, input logic [1:0] typ);
    ch_base_addr[ch*16 +: 16]  = addr;
    ch_base_count[ch*16 +: 16] = cnt;
    ch_xfer_type[ch*2 +: 2]    = typ;
    ch_load[ch] = 1'b1;
    tick();
    ch_load = '0;
  endtask

  // CPU model returns HLDA the cycle after it sees HRQ; EOP_N_IN / HLDA drop are injected in state S<k>.
  task automatic xfer(input int eop_at, input int abort_at, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (bus.HRQ) bus.HLDA = 1'b1;
      if (bus.DACK != 4'b0000) ok = 1'b1;
    end
    if (ok) begin
      grab(0);
      for (int k = 1; k <= 4; k++) begin
        bus.EOP_N_IN = (eop_at == k) ? 1'b0 : 1'b1;
        if (abort_at == k) bus.HLDA = 1'b0;
        tick();
        grab(k);
      end
    end
    bus.EOP_N_IN = 1'b1;
    bus.HLDA     = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.HRQ, bus.DACK, bus.idle_cycle, bus.active_cycle, bus.ior, bus.iow, bus.memr, bus.memw, bus.aen, bus.adstb, bus.eop} !== RST_PACK) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", {bus.HRQ, bus.DACK, bus.idle_cycle, bus.active_cycle, bus.ior, bus.iow, bus.memr, bus.memw, bus.aen, bus.adstb, bus.eop}, RST_PACK);
    end
    checks++;
    if (bus.addr_out !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", bus.addr_out); end
    checks++;
    if (tc_status !== 4'b0000) begin errors++; $display("FAIL reset_tc: got %b expected 0000", tc_status); end
  endtask

  task automatic test_write();
    bit ok;
    logic [15:0] exp_addr;
    load_ch(1, 16'h1234, 16'h0002, 2'b01);
    bus.DREQ = 4'b0010;
    for (int n = 0; n < 3; n++) begin
      exp_addr = 16'h1234 + 16'(n);
      xfer(0, 0, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wr%0d_grant: no DACK within 12 cycles, expected DACK 0010", n); end
      checks++;
      if (snap[0].dack !== 4'b0010 || snap[0].aen !== 1'b1 || snap[0].adstb !== 1'b1 || snap[0].active !== 1'b1 || snap[0].idle !== 1'b0) begin
        errors++;
        $display("FAIL wr%0d_s1: got dack=%b aen=%b adstb=%b act=%b idle=%b expected 0010 1 1 1 0", n, snap[0].dack, snap[0].aen, snap[0].adstb, snap[0].active, snap[0].idle);
      end
      checks++;
      if (snap[0].addr !== exp_addr) begin errors++; $display("FAIL wr%0d_addr: got %h expected %h", n, snap[0].addr, exp_addr); end
      checks++;
      if (snap[1].strb !== 4'b0111 || snap[1].adstb !== 1'b0) begin errors++; $display("FAIL wr%0d_s2: got strb=%b adstb=%b expected 0111 0", n, snap[1].strb, snap[1].adstb); end
      checks++;
      if (snap[2].strb !== 4'b0110) begin errors++; $display("FAIL wr%0d_s3: got strb=%b expected 0110", n, snap[2].strb); end
      checks++;
      if (snap[3].strb !== 4'b1111 || snap[3].eop !== (n == 2 ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL wr%0d_s4: got strb=%b eop=%b expected 1111 %b", n, snap[3].strb, snap[3].eop, (n == 2 ? 1'b0 : 1'b1));
      end
      checks++;
      if (snap[4].dack !== 4'b0000 || snap[4].aen !== 1'b0 || snap[4].hrq !== 1'b0 || snap[4].idle !== 1'b1 || snap[4].addr !== exp_addr + 16'h1) begin
        errors++;
        $display("FAIL wr%0d_post: got dack=%b aen=%b hrq=%b idle=%b addr=%h expected 0000 0 0 1 %h", n, snap[4].dack, snap[4].aen, snap[4].hrq, snap[4].idle, snap[4].addr, exp_addr + 16'h1);
      end
    end
    bus.DREQ = 4'b0000;
    checks++;
    if (snap[4].tc !== 4'b0010) begin errors++; $display("FAIL wr_tc: got %b expected 0010", snap[4].tc); end
    tick();
  endtask

  task automatic test_terminal_count();
    bit ok;
    bit seen;
    load_ch(1, 16'h1234, 16'h0002, 2'b01);
    load_ch(0, 16'hFFFF, 16'h0000, 2'b10);
    bus.DREQ = 4'b0001;
    xfer(0, 0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tc_grant: no DACK within 12 cycles, expected DACK 0001"); end
    checks++;
    if (snap[0].addr !== 16'hFFFF || snap[0].dack !== 4'b0001) begin errors++; $display("FAIL tc_s1: got addr=%h dack=%b expected ffff 0001", snap[0].addr, snap[0].dack); end
    checks++;
    if (snap[1].strb !== 4'b1101 || snap[2].strb !== 4'b1001) begin errors++; $display("FAIL tc_strobes: got s2=%b s3=%b expected 1101 1001", snap[1].strb, snap[2].strb); end
    checks++;
    if (snap[3].eop !== 1'b0 || snap[4].eop !== 1'b1) begin errors++; $display("FAIL tc_eop: got s4=%b post=%b expected 0 1", snap[3].eop, snap[4].eop); end
    checks++;
    if (snap[4].tc !== 4'b0001 || snap[4].addr !== 16'h0000) begin errors++; $display("FAIL tc_post: got tc=%b addr=%h expected 0001 0000", snap[4].tc, snap[4].addr); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.HRQ) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL tc_blocks: got HRQ=1 expected HRQ stays 0"); end
    load_ch(0, 16'h0040, 16'h0005, 2'b10);
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      tick();
      if (bus.HRQ) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b1) begin errors++; $display("FAIL tc_reload: got HRQ=0 expected HRQ=1 after ch_load"); end
    bus.DREQ = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_priority();
    bit ok;
    logic [3:0] exp_seq [4];
    load_ch(2, 16'h2000, 16'h0010, 2'b00);
    load_ch(3, 16'h3000, 16'h0010, 2'b01);
    bus.DREQ = 4'b1100;
    xfer(0, 0, ok);
    checks++;
    if (!ok || snap[0].dack !== 4'b0100 || snap[0].addr !== 16'h2000) begin
      errors++;
      $display("FAIL prio_first: got ok=%0d dack=%b addr=%h expected 1 0100 2000", ok, snap[0].dack, snap[0].addr);
    end
    checks++;
    if (snap[1].strb !== 4'b1111 || snap[2].strb !== 4'b1111) begin errors++; $display("FAIL prio_verify: got s2=%b s3=%b expected 1111 1111", snap[1].strb, snap[2].strb); end
    bus.DREQ = 4'b1000;
    xfer(0, 0, ok);
    checks++;
    if (!ok || snap[0].dack !== 4'b1000 || snap[0].addr !== 16'h3000) begin
      errors++;
      $display("FAIL prio_second: got ok=%0d dack=%b addr=%h expected 1 1000 3000", ok, snap[0].dack, snap[0].addr);
    end
    bus.DREQ = 4'b0101;
`ifdef DMA_ROTATING_PRIORITY_EN
    exp_seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`else
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    for (int n = 0; n < 4; n++) begin
      xfer(0, 0, ok);
      checks++;
      if (!ok || snap[0].dack !== exp_seq[n]) begin
        errors++;
        $display("FAIL prio_seq%0d: got ok=%0d dack=%b expected 1 %b", n, ok, snap[0].dack, exp_seq[n]);
      end
    end
    bus.DREQ = 4'b0000;
    tick();
  endtask

  task automatic test_withdraw_mask();
    bit seen;
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b1000;
    tick();
    checks++;
    if (bus.HRQ !== 1'b1) begin errors++; $display("FAIL wd_hrq_up: got %b expected 1", bus.HRQ); end
    bus.DREQ = 4'b0000;
    tick();
    checks++;
    if (bus.HRQ !== 1'b0 || bus.DACK !== 4'b0000 || bus.idle_cycle !== 1'b1) begin
      errors++;
      $display("FAIL wd_drop: got hrq=%b dack=%b idle=%b expected 0 0000 1", bus.HRQ, bus.DACK, bus.idle_cycle);
    end
    ch_mask  = 4'b1111;
    bus.DREQ = 4'b1111;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.HRQ) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL mask_all: got HRQ=1 expected HRQ stays 0"); end
    bus.DREQ = 4'b0000;
    ch_mask  = 4'b0000;
    tick();
  endtask

  task automatic test_abort();
    bit ok;
    load_ch(2, 16'h2200, 16'h0000, 2'b01);
    bus.DREQ = 4'b0100;
    xfer(0, 2, ok);
    checks++;
    if (!ok || snap[1].strb !== 4'b0111 || snap[1].dack !== 4'b0100) begin
      errors++;
      $display("FAIL abort_s2: got ok=%0d strb=%b dack=%b expected 1 0111 0100", ok, snap[1].strb, snap[1].dack);
    end
    checks++;
    if (snap[2].strb !== 4'b1111 || snap[2].dack !== 4'b0000 || snap[2].aen !== 1'b0) begin
      errors++;
      $display("FAIL abort_next: got strb=%b dack=%b aen=%b expected 1111 0000 0", snap[2].strb, snap[2].dack, snap[2].aen);
    end
    bus.DREQ = 4'b0000;
    tick();
    tick();
    checks++;
    if (tc_status[2] !== 1'b0) begin errors++; $display("FAIL abort_no_tc: got %b expected 0", tc_status[2]); end
    bus.DREQ = 4'b0100;
    xfer(0, 0, ok);
    bus.DREQ = 4'b0000;
    checks++;
    if (!ok || snap[0].addr !== 16'h2200 || snap[3].eop !== 1'b0 || snap[4].tc[2] !== 1'b1) begin
      errors++;
      $display("FAIL abort_unchanged: got ok=%0d addr=%h eop=%b tc2=%b expected 1 2200 0 1", ok, snap[0].addr, snap[3].eop, snap[4].tc[2]);
    end
    tick();
  endtask

  task automatic test_ext_eop();
    bit ok;
    load_ch(1, 16'h1000, 16'h0010, 2'b01);
    bus.DREQ = 4'b0010;
    xfer(3, 0, ok);
    bus.DREQ = 4'b0000;
    checks++;
    if (!ok || snap[2].eop !== 1'b1 || snap[3].eop !== 1'b0) begin
      errors++;
      $display("FAIL eop_drive: got ok=%0d s3=%b s4=%b expected 1 1 0", ok, snap[2].eop, snap[3].eop);
    end
    checks++;
    if (snap[4].tc[1] !== 1'b1 || snap[4].addr !== 16'h1001) begin
      errors++;
      $display("FAIL eop_post: got tc1=%b addr=%h expected 1 1001", snap[4].tc[1], snap[4].addr);
    end
    tick();
  endtask

  task automatic test_async_reset();
    bit ok;
    load_ch(3, 16'h3300, 16'h0005, 2'b10);
    bus.DREQ = 4'b1000;
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (bus.HRQ) bus.HLDA = 1'b1;
      if (bus.DACK != 4'b0000) ok = 1'b1;
    end
    tick();
    tick();
    checks++;
    if (!ok || bus.iow !== 1'b0 || bus.memr !== 1'b0 || bus.DACK !== 4'b1000) begin
      errors++;
      $display("FAIL rst_pre_s3: got ok=%0d iow=%b memr=%b dack=%b expected 1 0 0 1000", ok, bus.iow, bus.memr, bus.DACK);
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({bus.HRQ, bus.DACK, bus.idle_cycle, bus.active_cycle, bus.ior, bus.iow, bus.memr, bus.memw, bus.aen, bus.adstb, bus.eop} !== RST_PACK) begin
      errors++;
      $display("FAIL rst_async: got %b expected %b", {bus.HRQ, bus.DACK, bus.idle_cycle, bus.active_cycle, bus.ior, bus.iow, bus.memr, bus.memw, bus.aen, bus.adstb, bus.eop}, RST_PACK);
    end
    checks++;
    if (bus.addr_out !== 16'h0000 || tc_status !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async_regs: got addr=%h tc=%b expected 0000 0000", bus.addr_out, tc_status);
    end
    bus.DREQ = 4'b0000;
    bus.HLDA = 1'b0;
    #3 RESET_N = 1'b1;
    tick();
  endtask

  initial begin
    RESET_N       = 1'b0;
    cfg_enable    = 1'b1;
    ch_mask       = '0;
    ch_xfer_type  = '0;
    ch_load       = '0;
    ch_base_addr  = '0;
    ch_base_count = '0;
    bus.DREQ      = '0;
    bus.HLDA      = 1'b0;
    bus.EOP_N_IN  = 1'b1;
    #12 RESET_N = 1'b1;
    tick();
    test_reset();
    test_write();
    test_terminal_count();
    test_priority();
    test_withdraw_mask();
    test_abort();
    test_ext_eop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dma_timing_ctrl.md
Name: dma_timing_ctrl

Overview:
- Timing and priority controller for the 8237-style DMA engine.
- Arbitrates four DREQ lines and runs the HRQ/HLDA bus handshake.
- Sequences the SI/S0/S1/S2/S3/S4 transfer cycle and holds per-channel current address and word count.
- Drives the datapath control fields: idle/active cycle flags, ior, iow, aen, adstb, eop and the transfer address.

Parameters:
- NUM_CH, 4, number of DMA channels.
- ADDR_W, 16, transfer address width.
- CNT_W, 16, word count width.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- DREQ  in  NUM_CH  channel requests, active high.
- HLDA  in  1  hold acknowledge from CPU.
- EOP_N_IN  in  1  sampled external end-of-process, active low.
- cfg_enable  in  1  controller enable; 0 blocks new requests.
- ch_mask  in  NUM_CH  per-channel mask, 1 = ignore.
- ch_xfer_type  in  2*NUM_CH  per channel: 00 verify, 01 write (I/O->mem), 10 read (mem->I/O), 11 illegal (treated as verify).
- ch_load  in  NUM_CH  copy base address/count into current registers.
- ch_base_addr  in  ADDR_W*NUM_CH  base addresses.
- ch_base_count  in  CNT_W*NUM_CH  base counts (N means N+1 transfers).
- HRQ  out  1  hold request.
- DACK  out  NUM_CH  one-hot acknowledge.
- idle_cycle  out  1  high in SI/S0.
- active_cycle  out  1  high in S1-S4.
- ior, iow, memr, memw  out  1 each  active-low strobe drive values.
- aen  out  1  address enable.
- adstb  out  1  upper-address strobe.
- eop  out  1  active-low EOP drive value.
- addr_out  out  ADDR_W  current address of granted channel.
- tc_status  out  NUM_CH  sticky terminal-count flags; cleared by ch_load of that channel.

Behaviour:
- Reset values:
  - HRQ=0, DACK=0, idle_cycle=1, active_cycle=0.
  - ior=iow=memr=memw=1, eop=1, aen=0, adstb=0.
  - addr_out=0, tc_status=0, all current regs 0.
  - State = SI.
- Eligible channel: DREQ & ~ch_mask & ~tc_status, with cfg_enable=1.
- SI: on any eligible channel, go to S0 next cycle and assert HRQ.
- S0:
  - HRQ held.
  - If no channel remains eligible before HLDA, drop HRQ and return to SI.
  - On HLDA=1, latch the highest-priority eligible channel as grant and go to S1.
- S1: aen=1, adstb=1, DACK[grant]=1, addr_out valid, active_cycle=1.
- S2:
  - adstb=0.
  - Read strobe low: ior for write type, memr for read type, none for verify.
- S3: write strobe also low (memw for write, iow for read); read strobe held.
- S4:
  - All strobes high.
  - Current address += 1 (wraps FFFF->0000).
  - Count -= 1. If count was 0 before decrement (0->all-ones), TC: eop=0 for S4 only, tc_status[grant] set.
  - DACK, aen and HRQ drop at S4 exit; return to SI.
- Each grant performs exactly one transfer (single mode). A new request arbitrates from SI.
- Minimum cycle is 6 clocks SI->SI with HLDA already high.
- EOP_N_IN low in S2 or S3 is treated as TC: S4 completes normally, counters update, tc_status set.
- HLDA low in S1-S3 aborts:
  - Strobes go high and DACK/aen drop the next cycle.
  - No counter update; return to SI.
- ch_load on the granted channel in the same cycle as its S4 update: load wins.
- Changes to DREQ or ch_mask after grant do not affect the cycle in progress.
- Priority is fixed: channel 0 highest, channel NUM_CH-1 lowest.
- Asynchronous reset mid-cycle immediately forces all outputs to reset values.

Optional Feature:
- Macro: DMA_ROTATING_PRIORITY_EN.
- Defined: after a completed S4, the serviced channel becomes lowest priority and the next channel up becomes highest. An aborted cycle does not rotate. Reset priority order is 0 > 1 > 2 > 3.
- Undefined: fixed priority as above.

Test Plan:
- Write transfer:
  - Stimulus: load ch1 addr 0x1234, count 0x0002, type 01. DREQ[1]=1, HLDA returned 1 cycle after HRQ.
  - Response: DACK=0010. In S2 ior=0, memw=1; in S3 ior=0, memw=0. After S4, addr_out next grant = 0x1235, count 0x0001. No eop.
- Terminal count:
  - Stimulus: load ch0 count 0x0000, addr 0xFFFF, type 10.
  - Response: memr low in S2, iow low in S3. eop=0 during S4, tc_status=0001, address wraps to 0x0000. Further DREQ[0] yields no HRQ until ch_load[0].
- Priority:
  - Stimulus: DREQ=1100 together.
  - Response: ch2 served first, then ch3.
  - With DMA_ROTATING_PRIORITY_EN and DREQ=0101 held: grants alternate 0, 2, 0, 2.
- Request withdrawn / masked:
  - Stimulus: DREQ[3] drops in S0 before HLDA.
  - Response: HRQ falls, state returns to SI, no DACK.
  - Stimulus: ch_mask=1111 with DREQ=1111.
  - Response: HRQ stays 0.
- HLDA abort:
  - Stimulus: HLDA deasserted in S2 of a ch2 write.
  - Response: ior back to 1 and DACK=0 next cycle; ch2 address and count unchanged.
- External EOP and reset:
  - Stimulus: EOP_N_IN=0 in S3 of a count 0x0010 transfer.
  - Response: tc_status set, count = 0x000F.
  - Stimulus: RESET_N asserted in S3.
  - Response: all outputs return to reset values without waiting for a clock edge.
